key_event_arbiter: RTL and testbench
====================================

KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 SHALL have parameter TS_W, default 16, timestamp width in bits.
REQ-002 SHALL have parameter TICK_DIV, default 100000, clk_in cycles per timestamp tick (1 ms at 100 MHz).
REQ-003 SHALL have port clk_in  input  1  system clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports a, s, k, l  input  1 each  lane key levels, lanes 0..3, already synchronous to clk_in, 1 = held.
REQ-006 SHALL have port enter  input  1  start key level, synchronous to clk_in.
REQ-007 SHALL have port game_run  input  1  enables event capture when 1.
REQ-008 SHALL have port evt_valid  output  1  event offered to the judge.
REQ-009 SHALL have port evt_ready  input  1  judge accepts the event.
REQ-010 SHALL have port evt_lane  output  2  lane of the offered event.
REQ-011 SHALL have port evt_press  output  1  1 = press, 0 = release.
REQ-012 SHALL have port evt_time  output  TS_W  timestamp of the offered event.
REQ-013 SHALL have port start_pulse  output  1  one-cycle pulse on the rising edge of enter.
REQ-014 SHALL have port overflow  output  1  sticky flag, set when an event is dropped.

Function
REQ-015 SHALL run a prescaler 0..TICK_DIV-1; on wrap, timestamp increments modulo 2^TS_W (all-ones wraps to 0).
REQ-016 SHALL clear the prescaler, timestamp and overflow in the cycle start_pulse is asserted.
REQ-017 SHALL register each lane level once per cycle; press edge = previous 0, current 1; release edge = previous 1, current 0.
REQ-018 SHALL capture an edge only when game_run = 1; with game_run = 0, edges are ignored and pending slots still drain.
REQ-019 SHALL hold one pending slot per lane (valid, type, timestamp); the timestamp is the value in the cycle the edge is detected.
REQ-020 SHALL, when an edge hits an occupied slot not being cleared that cycle, drop the new edge, keep the old slot and set overflow.
REQ-021 SHALL, when an edge hits a slot being cleared by a handshake in the same cycle, load the new edge with no overflow.
REQ-022 SHALL implement FSM IDLE/OFFER; IDLE: when any slot is valid, grant round-robin starting at (last_grant+1) mod 4, latch lane/type/time into the output registers, go to OFFER.
REQ-023 SHALL, in OFFER, assert evt_valid with evt_lane/evt_press/evt_time stable until evt_ready = 1.
REQ-024 SHALL, on evt_valid and evt_ready, clear the granted slot, set last_grant to that lane, deassert evt_valid next cycle and return to IDLE.
REQ-025 SHALL achieve latency: key edge at input in cycle N -> slot valid N+1 -> evt_valid N+2 when the FSM is idle; throughput one event per 2 cycles.
REQ-026 SHALL drive evt_valid = 0 in IDLE; evt_lane/evt_press/evt_time SHALL hold their last values.
REQ-027 SHALL make start_pulse independent of game_run and of the FSM.

Reset
REQ-028 SHALL, on rst low, asynchronously clear: evt_valid, evt_lane, evt_press, evt_time, start_pulse, overflow, all slots, prescaler, timestamp, edge registers; FSM to IDLE; last_grant = 3 (lane 0 first).
REQ-029 SHALL, on reset mid-offer, drop the offered event and every pending event; keys held across reset release do not produce a press edge.

Configuration
REQ-030 SHALL use macro HOLD_RELEASE_EN: defined -> release edges are captured and reported with evt_press = 0 (long-note support); undefined -> only press edges are captured, evt_press is constant 1, release edges never set overflow.

Verification
REQ-031 SHALL cover: TICK_DIV=4, game_run=1, a rises at cycle 10 -> evt_valid at 12, evt_lane=0, evt_press=1, evt_time=2; evt_ready=1 -> evt_valid=0 at 13.
REQ-032 SHALL cover: a,s,k,l rise in the same cycle, evt_ready held 1 -> lanes granted 0,1,2,3 on successive offers, 2 cycles apart, no overflow.
REQ-033 SHALL cover: evt_ready=0, s pressed, then released (HOLD_RELEASE_EN defined) -> first offer lane 1 press stays stable; release dropped, overflow=1; enter rise -> start_pulse one cycle, overflow=0, timestamp=0.
REQ-034 SHALL cover: game_run=0, k toggles -> no evt_valid; already-pending lane-2 event still delivered.
REQ-035 SHALL cover: timestamp at 16'hFFFF, tick occurs -> 0; rst low while evt_valid=1 -> all outputs 0 asynchronously; with HOLD_RELEASE_EN undefined, l release -> no event.

Source files
------------

// File: rtl/key_event_arbiter_if.sv
// Event port between the key arbiter (master) and the judge (slave):
// valid/ready handshake carrying lane, press/release type and timestamp.
interface key_event_arbiter_if #(
   parameter int TS_W = 16
);
   logic            evt_valid;
   logic            evt_ready;
   logic [1:0]      evt_lane;
   logic            evt_press;
   logic [TS_W-1:0] evt_time;

   modport master (
      output evt_valid,
      output evt_lane,
      output evt_press,
      output evt_time,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_lane,
      input  evt_press,
      input  evt_time,
      output evt_ready
   );
endinterface

// File: rtl/key_event_arbiter.sv
// Timestamps key edges on four lanes into per-lane pending slots and offers them
// round-robin on a valid/ready port. Define HOLD_RELEASE_EN to also report releases.
module key_event_arbiter #(
   parameter int TS_W     = 16,
   parameter int TICK_DIV = 100000
) (
   input  logic                clk_in,
   input  logic                rst,
   input  logic                a,
   input  logic                s,
   input  logic                k,
   input  logic                l,
   input  logic                enter,
   input  logic                game_run,
   key_event_arbiter_if.master evt,
   output logic                start_pulse,
   output logic                overflow
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_OFFER = 1'b1
   } state_t;

   state_t          state_q, state_d;

   logic [3:0]      key_now;
   logic [3:0]      key_q;
   logic            armed_q;
   logic            enter_q;
   logic            start_det;
   logic            start_pulse_q;
   logic            overflow_q;
   logic [PW-1:0]   presc_q;
   logic [TS_W-1:0] ts_q;
   logic            tick;

   logic [3:0]      press_edge;
   logic [3:0]      cap_edge;
   logic [3:0]      slot_vld;
   logic [TS_W-1:0] slot_ts [4];
   logic [3:0]      slot_clr;
   logic [3:0]      drop;
   logic            handshake;

   logic [1:0]      last_grant_q, last_grant_d;
   logic [1:0]      grant_lane;
   logic            grant_any;
   logic [1:0]      cand;

   logic [1:0]      evt_lane_q, evt_lane_d;
   logic [TS_W-1:0] evt_time_q, evt_time_d;

   assign key_now    = {l, k, s, a};
   // armed_q is low for the first cycle after reset so held keys only seed key_q
   assign press_edge = armed_q ? (key_now & ~key_q) : 4'b0000;
   assign start_det  = armed_q & enter & ~enter_q;
   assign tick       = (presc_q == PRESC_MAX);
   assign handshake  = (state_q == S_OFFER) && evt.evt_ready;
   assign slot_clr   = handshake ? (4'b0001 << evt_lane_q) : 4'b0000;

`ifdef HOLD_RELEASE_EN
   logic [3:0] release_edge;
   logic [3:0] slot_press;
   logic       evt_press_q, evt_press_d;

   assign release_edge = armed_q ? (~key_now & key_q) : 4'b0000;
   assign cap_edge     = (press_edge | release_edge) & {4{game_run}};
`else
   assign cap_edge     = press_edge & {4{game_run}};
`endif

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         armed_q       <= 1'b0;
         key_q         <= 4'b0000;
         enter_q       <= 1'b0;
         start_pulse_q <= 1'b0;
         overflow_q    <= 1'b0;
         presc_q       <= '0;
         ts_q          <= '0;
      end else begin
         armed_q       <= 1'b1;
         key_q         <= key_now;
         enter_q       <= enter;
         start_pulse_q <= start_det;
         // a start clears the time base and the sticky flag together, winning over a drop
         if (start_det) begin
            presc_q    <= '0;
            ts_q       <= '0;
            overflow_q <= 1'b0;
         end else begin
            presc_q <= tick ? '0 : presc_q + PW'(1);
            if (tick) begin
               ts_q <= ts_q + TS_W'(1);
            end
            if (|drop) begin
               overflow_q <= 1'b1;
            end
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_slot
         logic            load;
         logic            vld_q;
         logic [TS_W-1:0] ts_slot_q;

         // a slot freed by this cycle's handshake may take a new edge at once
         assign load     = cap_edge[gi] && (!vld_q || slot_clr[gi]);
         assign drop[gi] = cap_edge[gi] && vld_q && !slot_clr[gi];

         always_ff @(posedge clk_in or negedge rst) begin
            if (!rst) begin
               vld_q     <= 1'b0;
               ts_slot_q <= '0;
            end else if (load) begin
               vld_q     <= 1'b1;
               ts_slot_q <= ts_q;
            end else if (slot_clr[gi]) begin
               vld_q     <= 1'b0;
            end
         end

         assign slot_vld[gi] = vld_q;
         assign slot_ts[gi]  = ts_slot_q;

`ifdef HOLD_RELEASE_EN
         logic press_slot_q;

         always_ff @(posedge clk_in or negedge rst) begin
            if (!rst) begin
               press_slot_q <= 1'b0;
            end else if (load) begin
               press_slot_q <= press_edge[gi];
            end
         end

         assign slot_press[gi] = press_slot_q;
`endif
      end
   endgenerate

   // Round-robin search starting one lane past the last accepted grant.
   always_comb begin
      grant_any  = 1'b0;
      grant_lane = last_grant_q;
      cand       = last_grant_q;
      for (int i = 0; i < 4; i++) begin
         cand = cand + 2'd1;
         if (!grant_any && slot_vld[cand]) begin
            grant_any  = 1'b1;
            grant_lane = cand;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         last_grant_q <= 2'd3;
         evt_lane_q   <= 2'd0;
         evt_time_q   <= '0;
`ifdef HOLD_RELEASE_EN
         evt_press_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         evt_lane_q   <= evt_lane_d;
         evt_time_q   <= evt_time_d;
`ifdef HOLD_RELEASE_EN
         evt_press_q  <= evt_press_d;
`endif
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      evt_lane_d   = evt_lane_q;
      evt_time_d   = evt_time_q;
`ifdef HOLD_RELEASE_EN
      evt_press_d  = evt_press_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (grant_any) begin
               state_d    = S_OFFER;
               evt_lane_d = grant_lane;
               evt_time_d = slot_ts[grant_lane];
`ifdef HOLD_RELEASE_EN
               evt_press_d = slot_press[grant_lane];
`endif
            end
         end
         S_OFFER: begin
            if (evt.evt_ready) begin
               state_d      = S_IDLE;
               last_grant_d = evt_lane_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign evt.evt_valid = (state_q == S_OFFER);
   assign evt.evt_lane  = evt_lane_q;
   assign evt.evt_time  = evt_time_q;
`ifdef HOLD_RELEASE_EN
   assign evt.evt_press = evt_press_q;
`else
   assign evt.evt_press = 1'b1;
`endif
   assign start_pulse   = start_pulse_q;
   assign overflow      = overflow_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Bench for key_event_arbiter: directed scenarios plus random key traffic, checked
// every cycle against a behavioural model of the event rules.
module tb_key_event_arbiter;
   localparam int TS_W     = 8;
   localparam int TICK_DIV = 4;
`ifdef HOLD_RELEASE_EN
   localparam bit REL_EN = 1'b1;
`else
   localparam bit REL_EN = 1'b0;
`endif

   logic clk_in = 1'b0;
   logic rst    = 1'b0;
   logic a = 1'b0, s = 1'b0, k = 1'b0, l = 1'b0;
   logic enter = 1'b0, game_run = 1'b0;
   logic start_pulse, overflow;

   key_event_arbiter_if #(.TS_W(TS_W)) evt_if ();

   key_event_arbiter #(.TS_W(TS_W), .TICK_DIV(TICK_DIV)) dut (
      .clk_in      (clk_in),
      .rst         (rst),
      .a           (a),
      .s           (s),
      .k           (k),
      .l           (l),
      .enter       (enter),
      .game_run    (game_run),
      .evt         (evt_if),
      .start_pulse (start_pulse),
      .overflow    (overflow)
   );

   always #5 clk_in = ~clk_in;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit       m_armed;
   bit [3:0] m_prev;
   bit       m_enter_prev;
   bit       m_pend  [4];
   bit       m_ppress[4];
   int       m_pts   [4];
   bit       m_valid;
   int       m_lane;
   bit       m_press;
   int       m_time;
   int       m_last;
   bit       m_start;
   bit       m_ovf;
   int       m_cyc;

   task automatic model_reset();
      m_armed = 0; m_prev = '0; m_enter_prev = 0;
      for (int i = 0; i < 4; i++) begin
         m_pend[i] = 0; m_ppress[i] = 0; m_pts[i] = 0;
      end
      m_valid = 0; m_lane = 0; m_press = 0; m_time = 0; m_last = 3;
      m_start = 0; m_ovf = 0; m_cyc = 0;
   endtask

   task automatic model_step();
      bit [3:0] lv;
      bit [3:0] pe;
      bit [3:0] re;
      bit       hs;
      bit       drop;
      bit       sdet;
      int       ts_now;
      int       pick;
      int       c;
      lv     = {l, k, s, a};
      ts_now = (m_cyc / TICK_DIV) % (1 << TS_W);
      hs     = m_valid && evt_if.evt_ready;
      pe     = m_armed ? (lv & ~m_prev) : 4'b0000;
      re     = m_armed ? (~lv & m_prev) : 4'b0000;
      sdet   = m_armed && enter && !m_enter_prev;
      if (hs) begin
         m_valid = 0;
         m_last  = m_lane;
         m_pend[m_lane] = 0;
      end else if (!m_valid) begin
         pick = -1;
         for (int i = 1; i <= 4; i++) begin
            c = (m_last + i) % 4;
            if (pick < 0 && m_pend[c]) pick = c;
         end
         if (pick >= 0) begin
            m_valid = 1;
            m_lane  = pick;
            m_press = m_ppress[pick];
            m_time  = m_pts[pick];
         end
      end
      drop = 0;
      for (int ln = 0; ln < 4; ln++) begin
         if (game_run && (pe[ln] || (REL_EN && re[ln]))) begin
            if (m_pend[ln]) drop = 1;
            else begin
               m_pend[ln]   = 1;
               m_ppress[ln] = pe[ln];
               m_pts[ln]    = ts_now;
            end
         end
      end
      m_start = sdet;
      if (sdet) begin
         m_cyc = 0;
         m_ovf = 0;
      end else begin
         m_cyc++;
         if (drop) m_ovf = 1;
      end
      m_armed      = 1;
      m_prev       = lv;
      m_enter_prev = enter;
   endtask

   always @(posedge clk_in) begin
      if (rst) model_step();
   end

   always @(negedge clk_in) begin
      if (rst) begin
         chk("m_valid", evt_if.evt_valid, m_valid);
         chk("m_lane", evt_if.evt_lane, m_lane);
         chk("m_press", evt_if.evt_press, REL_EN ? m_press : 1'b1);
         chk("m_time", evt_if.evt_time, m_time);
         chk("m_start", start_pulse, m_start);
         chk("m_ovf", overflow, m_ovf);
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_reset();
      @(negedge clk_in);
      rst = 0;
      model_reset();
      {a, s, k, l} = 4'b0000;
      enter = 0; game_run = 0; evt_if.evt_ready = 0;
      repeat (2) @(negedge clk_in);
      rst = 1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      bit found;
      evt_if.evt_ready = 0;
      model_reset();
      repeat (3) @(negedge clk_in);
      chk("rst_valid", evt_if.evt_valid, 0);
      chk("rst_lane", evt_if.evt_lane, 0);
      chk("rst_time", evt_if.evt_time, 0);
      chk("rst_press", evt_if.evt_press, REL_EN ? 0 : 1);
      chk("rst_start", start_pulse, 0);
      chk("rst_ovf", overflow, 0);

      // a rises in cycle 10 with TICK_DIV=4 -> offered in cycle 12 with time 2
      do_reset();
      game_run = 1; evt_if.evt_ready = 1;
      repeat (10) @(negedge clk_in);
      a = 1;
      repeat (2) @(negedge clk_in);
      chk("a_valid12", evt_if.evt_valid, 1);
      chk("a_lane", evt_if.evt_lane, 0);
      chk("a_press", evt_if.evt_press, 1);
      chk("a_time", evt_if.evt_time, 2);
      @(negedge clk_in);
      chk("a_valid13", evt_if.evt_valid, 0);
      a = 0;
      repeat (6) @(negedge clk_in);

      // four simultaneous presses -> lanes 0..3 two cycles apart
      do_reset();
      game_run = 1; evt_if.evt_ready = 1;
      repeat (3) @(negedge clk_in);
      {a, s, k, l} = 4'b1111;
      repeat (2) @(negedge clk_in);
      chk("rr_valid0", evt_if.evt_valid, 1);
      chk("rr_lane0", evt_if.evt_lane, 0);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk_in);
         chk("rr_gap", evt_if.evt_valid, 0);
         @(negedge clk_in);
         chk("rr_valid", evt_if.evt_valid, 1);
         chk("rr_lane", evt_if.evt_lane, i);
      end
      chk("rr_ovf", overflow, 0);
      {a, s, k, l} = 4'b0000;
      repeat (12) @(negedge clk_in);

      // stalled judge: release of s collides with the pending press
      evt_if.evt_ready = 0;
      s = 1;
      repeat (2) @(negedge clk_in);
      chk("s_valid", evt_if.evt_valid, 1);
      chk("s_lane", evt_if.evt_lane, 1);
      s = 0;
      @(negedge clk_in);
      chk("s_stable_lane", evt_if.evt_lane, 1);
      chk("s_stable_press", evt_if.evt_press, 1);
      chk("s_ovf", overflow, REL_EN ? 1 : 0);
      @(negedge clk_in);
      chk("s_stable_valid", evt_if.evt_valid, 1);
      enter = 1;
      @(negedge clk_in);
      chk("st_pulse", start_pulse, 1);
      chk("st_ovf_clr", overflow, 0);
      enter = 0; k = 1; evt_if.evt_ready = 1;
      @(negedge clk_in);
      chk("st_pulse_one", start_pulse, 0);
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         if (evt_if.evt_valid && evt_if.evt_lane == 2'd2) found = 1;
         else @(negedge clk_in);
      end
      chk("st_k_offered", found, 1);
      if (found) chk("st_k_time0", evt_if.evt_time, 0);

      // game_run low: toggles of k ignored, pending lane-2 event still drained
      k = 0;
      repeat (6) @(negedge clk_in);
      evt_if.evt_ready = 0;
      k = 1;
      @(negedge clk_in);
      game_run = 0; k = 0;
      @(negedge clk_in); k = 1;
      @(negedge clk_in); k = 0;
      @(negedge clk_in); k = 1;
      @(negedge clk_in);
      evt_if.evt_ready = 1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (evt_if.evt_valid && evt_if.evt_ready) begin
            cnt++;
            chk("gr_lane", evt_if.evt_lane, 2);
         end
         @(negedge clk_in);
      end
      chk("gr_count", cnt, 1);
      k = 0;
      @(negedge clk_in);
      game_run = 1;
      repeat (4) @(negedge clk_in);

      // timestamp wrap: 255 just before the 1024th cycle after start, 0 after
      enter = 1;
      @(negedge clk_in);
      chk("wr_start", start_pulse, 1);
      enter = 0;
      repeat (1023) @(negedge clk_in);
      a = 1;
      @(negedge clk_in);
      s = 1;
      @(negedge clk_in);
      chk("wr_valid_a", evt_if.evt_valid, 1);
      chk("wr_lane_a", evt_if.evt_lane, 0);
      chk("wr_time_ff", evt_if.evt_time, 255);
      repeat (2) @(negedge clk_in);
      chk("wr_valid_s", evt_if.evt_valid, 1);
      chk("wr_lane_s", evt_if.evt_lane, 1);
      chk("wr_time_00", evt_if.evt_time, 0);
      a = 0; s = 0;
      repeat (10) @(negedge clk_in);

      // asynchronous reset while an event is offered; held key gives no press after
      evt_if.evt_ready = 0;
      l = 1;
      repeat (3) @(negedge clk_in);
      chk("ar_valid_before", evt_if.evt_valid, 1);
      #2;
      rst = 0;
      model_reset();
      #1;
      chk("ar_valid", evt_if.evt_valid, 0);
      chk("ar_lane", evt_if.evt_lane, 0);
      chk("ar_time", evt_if.evt_time, 0);
      chk("ar_start", start_pulse, 0);
      chk("ar_ovf", overflow, 0);
      @(negedge clk_in);
      rst = 1; evt_if.evt_ready = 1; game_run = 1;
      cnt = 0;
      repeat (6) begin
         @(negedge clk_in);
         if (evt_if.evt_valid) cnt++;
      end
      chk("ar_no_press", cnt, 0);
      l = 0;
      cnt = 0;
      repeat (6) begin
         @(negedge clk_in);
         if (evt_if.evt_valid) cnt++;
      end
      chk("rel_events", cnt, REL_EN ? 1 : 0);

      // random traffic against the model
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk_in);
         if ($urandom_range(0, 7) == 0) a = ~a;
         if ($urandom_range(0, 7) == 0) s = ~s;
         if ($urandom_range(0, 7) == 0) k = ~k;
         if ($urandom_range(0, 7) == 0) l = ~l;
         if ($urandom_range(0, 29) == 0) enter = ~enter;
         game_run         = ($urandom_range(0, 9) != 0);
         evt_if.evt_ready = ($urandom_range(0, 2) != 0);
      end
      repeat (4) @(negedge clk_in);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
